dma_host_programmer: RTL and testbench

//  Host-side initiator for the DMA slave programming port (CS_N/IOR_N/IOW_N/A3..A0/DB).

---
 rtl/dma_host_programmer.sv | 193 +++++++++++++++++++
 tb/tb_dma_host_programmer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_host_programmer.sv
// Host-side initiator for the DMA slave programming port.
// Expands one register command into byte-wide CS_N/IOR_N/IOW_N bus cycles.
module dma_host_programmer #(
    parameter int ADDRESSWIDTH  = 16,
    parameter int DATAWIDTH     = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  logic [2:0]              cmdOp,
    input  logic [1:0]              cmdChannel,
    input  logic [ADDRESSWIDTH-1:0] cmdData,
    output logic                    rspValid,
    output logic [ADDRESSWIDTH-1:0] rspData,
    input  logic                    HLDA,
    output logic                    CS_N,
    output logic                    IOR_N,
    output logic                    IOW_N,
    output logic [3:0]              A,
    output logic [DATAWIDTH-1:0]    DB_OUT,
    output logic                    DB_OE,
    input  logic [DATAWIDTH-1:0]    DB_IN
);

    localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, DONE, WAIT_BUS
    } state_t;

    state_t                  state, stateNext;
    logic [CW-1:0]           cnt, cntNext;
    logic [1:0]              step, stepNext;
    logic [2:0]              opQ;
    logic [1:0]              chQ;
    logic [ADDRESSWIDTH-1:0] dataQ;
    logic [DATAWIDTH-1:0]    rdLo, rdHi;
    logic                    sampleRd;
    logic                    is16, clrStep, isRead, busActive;
    logic [1:0]              lastStep;
    logic [3:0]              regAddr;
    logic [DATAWIDTH-1:0]    wrByte;

    // 16-bit ops (0,1,4,5) all have opcode bit 1 clear
    assign is16      = ~opQ[1];
    assign lastStep  = is16 ? 2'd2 : 2'd0;
    assign clrStep   = is16 && (step == 2'd0);
    assign isRead    = (opQ == 3'd4 || opQ == 3'd5 || opQ == 3'd6) && !clrStep;
    assign busActive = (state == SETUP) || (state == STROBE) || (state == HOLD);

    assign cmdReady = (state == IDLE) && !HLDA;
    assign rspValid = (state == DONE);
    assign CS_N     = !busActive;
    assign IOW_N    = !((state == STROBE) && !isRead);
    assign IOR_N    = !((state == STROBE) && isRead);
    assign DB_OE    = busActive && !isRead;
    assign A        = busActive ? (clrStep ? 4'b1100 : regAddr) : 4'b0000;
    assign DB_OUT   = (busActive && !isRead) ? wrByte : '0;

    always_comb begin
        regAddr = 4'b0000;
        wrByte  = '0;
        unique case (opQ)
            3'd0: begin
                regAddr = {1'b0, chQ, 1'b0};
                wrByte  = (step == 2'd2) ? dataQ[ADDRESSWIDTH-1 -: DATAWIDTH]
                                         : dataQ[DATAWIDTH-1:0];
            end
            3'd1: begin
                regAddr = {1'b0, chQ, 1'b1};
                wrByte  = (step == 2'd2) ? dataQ[ADDRESSWIDTH-1 -: DATAWIDTH]
                                         : dataQ[DATAWIDTH-1:0];
            end
            3'd2: begin
                regAddr = 4'b1000;
                wrByte  = dataQ[DATAWIDTH-1:0];
            end
            3'd3: begin
                regAddr = 4'b1011;
                wrByte  = {dataQ[DATAWIDTH-1:2], chQ};
            end
            3'd4: regAddr = {1'b0, chQ, 1'b0};
            3'd5: regAddr = {1'b0, chQ, 1'b1};
            3'd6: regAddr = 4'b1000;
            3'd7: regAddr = 4'b1100;
            default: regAddr = 4'b0000;
        endcase
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stepNext  = step;
        sampleRd  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmdValid && cmdReady) begin
                    stateNext = SETUP;
                    cntNext   = SETUP_LOAD;
                    stepNext  = 2'd0;
                end
            end
            SETUP: begin
                if (HLDA) begin
                    stateNext = WAIT_BUS;
                end else if (cnt == '0) begin
                    stateNext = STROBE;
                    cntNext   = STROBE_LOAD;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (HLDA) begin
                    stateNext = WAIT_BUS;
                end else if (cnt == '0) begin
                    stateNext = HOLD;
                    sampleRd  = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (HLDA) begin
                    stateNext = WAIT_BUS;
                end else if (step == lastStep) begin
                    stateNext = DONE;
                end else begin
                    stateNext = SETUP;
                    cntNext   = SETUP_LOAD;
                    stepNext  = step + 1'b1;
                end
            end
            DONE: stateNext = IDLE;
            // Restart from the first bus cycle; partial reads are re-fetched
            WAIT_BUS: begin
                if (!HLDA) begin
                    stateNext = SETUP;
                    cntNext   = SETUP_LOAD;
                    stepNext  = 2'd0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= 2'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            step  <= stepNext;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            opQ     <= 3'd0;
            chQ     <= 2'd0;
            dataQ   <= '0;
            rdLo    <= '0;
            rdHi    <= '0;
            rspData <= '0;
        end else begin
            if (state == IDLE && cmdValid && cmdReady) begin
                opQ   <= cmdOp;
                chQ   <= cmdChannel;
                dataQ <= cmdData;
            end
            if (sampleRd && isRead) begin
                if (step == 2'd2) rdHi <= DB_IN;
                else              rdLo <= DB_IN;
            end
            if (state == HOLD && stateNext == DONE) begin
                unique case (1'b1)
                    (opQ == 3'd6): rspData <= ADDRESSWIDTH'(rdLo);
                    (opQ == 3'd4 || opQ == 3'd5): rspData <= ADDRESSWIDTH'({rdHi, rdLo});
                    default: rspData <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_host_programmer.sv
// Scoreboard bench for dma_host_programmer: bus-cycle and response queues
// filled by directed stimulus, drained by independent monitors.
module tb_dma_host_programmer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [2:0]  cmdOp = 3'd0;
    logic [1:0]  cmdChannel = 2'd0;
    logic [15:0] cmdData = 16'h0;
    logic        rspValid;
    logic [15:0] rspData;
    logic        HLDA = 1'b0;
    logic        CS_N, IOR_N, IOW_N, DB_OE;
    logic [3:0]  A;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN = 8'h00;

    dma_host_programmer dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdChannel(cmdChannel), .cmdData(cmdData),
        .rspValid(rspValid), .rspData(rspData),
        .HLDA(HLDA), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .A(A), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(DB_IN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] addr;
        logic       wr;
        logic [7:0] db;
        logic       chkDb;
    } bus_t;

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          hs;
    } rsp_t;

    bus_t       busQ[$];
    rsp_t       rspQ[$];
    logic [7:0] rdQ[$];
    int         total = 0;
    int         bad = 0;
    int         cycCount = 0;
    logic       prevStrobe = 1'b0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    always @(posedge CLK) cycCount <= cycCount + 1;

    // Bus monitor: checks each strobe against the expected cycle, serves reads
    always @(negedge CLK) begin
        logic strobe;
        bus_t e;
        strobe = !IOR_N || !IOW_N;
        if (!IOR_N && !IOW_N) begin
            bad++;
            $display("FAIL strobes_both_low: IOR_N=%b IOW_N=%b", IOR_N, IOW_N);
        end
        if (strobe && !prevStrobe) begin
            if (busQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected: got A=%h expected none", A);
            end else begin
                e = busQ.pop_front();
                chk("bus_addr", {28'h0, A}, {28'h0, e.addr});
                chk("bus_cs", {31'h0, CS_N}, 32'h0);
                chk("bus_dir_w", {31'h0, !IOW_N}, {31'h0, e.wr});
                chk("bus_oe", {31'h0, DB_OE}, {31'h0, e.wr});
                if (e.chkDb) chk("bus_db", {24'h0, DB_OUT}, {24'h0, e.db});
                if (!e.wr && rdQ.size() != 0) DB_IN = rdQ.pop_front();
            end
        end
        prevStrobe = strobe;
    end

    // Response monitor
    always @(negedge CLK) begin
        rsp_t r;
        if (RESET_N && rspValid) begin
            if (rspQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got %h expected none", rspData);
            end else begin
                r = rspQ.pop_front();
                chk("rsp_data", {16'h0, rspData}, {16'h0, r.data});
                if (r.lat >= 0) chk("rsp_latency", cycCount - r.hs + 1, r.lat);
            end
        end
    end

    task automatic busExp(input logic [3:0] a, input logic wr,
                          input logic [7:0] db, input logic cd);
        bus_t e;
        e.addr = a; e.wr = wr; e.db = db; e.chkDb = cd;
        busQ.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] ch,
                         input logic [15:0] d, input logic [15:0] exp,
                         input int lat);
        int w = 0;
        rsp_t r;
        while (!cmdReady && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 200) chk("ready_timeout", 32'd0, 32'd1);
        cmdValid = 1'b1; cmdOp = op; cmdChannel = ch; cmdData = d;
        @(posedge CLK);
        @(negedge CLK);
        cmdValid = 1'b0;
        r.data = exp; r.lat = lat; r.hs = cycCount;
        rspQ.push_back(r);
    endtask

    task automatic waitDone();
        int w = 0;
        while (rspQ.size() != 0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 200) chk("done_timeout", 32'd0, 32'd1);
        chk("bus_queue_empty", busQ.size(), 0);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_cs", {31'h0, CS_N}, 32'h1);
        chk("rst_ior", {31'h0, IOR_N}, 32'h1);
        chk("rst_iow", {31'h0, IOW_N}, 32'h1);
        chk("rst_a", {28'h0, A}, 32'h0);
        chk("rst_db", {24'h0, DB_OUT}, 32'h0);
        chk("rst_oe", {31'h0, DB_OE}, 32'h0);
        chk("rst_rspv", {31'h0, rspValid}, 32'h0);
        chk("rst_rspd", {16'h0, rspData}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rst_ready", {31'h0, cmdReady}, 32'h1);

        // WR_BASE_ADDR ch2 1234
        busExp(4'b1100, 1, 8'h00, 0);
        busExp(4'b0100, 1, 8'h34, 1);
        busExp(4'b0100, 1, 8'h12, 1);
        issue(3'd0, 2'd2, 16'h1234, 16'h0000, 13);
        @(negedge CLK);
        chk("busy_ready", {31'h0, cmdReady}, 32'h0);
        waitDone();

        // RD_CUR_WC ch1 -> ABCD
        busExp(4'b1100, 1, 8'h00, 0);
        busExp(4'b0011, 0, 8'h00, 0);
        busExp(4'b0011, 0, 8'h00, 0);
        rdQ.push_back(8'hCD);
        rdQ.push_back(8'hAB);
        issue(3'd5, 2'd1, 16'h0000, 16'hABCD, 13);
        waitDone();
        chk("rsp_hold", {16'h0, rspData}, 32'h0000ABCD);

        // WR_MODE ch3 48 -> 4B
        busExp(4'b1011, 1, 8'h4B, 1);
        issue(3'd3, 2'd3, 16'h0048, 16'h0000, 5);
        waitDone();

        // WR_COMMAND 04
        busExp(4'b1000, 1, 8'h04, 1);
        issue(3'd2, 2'd0, 16'h0004, 16'h0000, 5);
        waitDone();

        // RD_STATUS 0F
        busExp(4'b1000, 0, 8'h00, 0);
        rdQ.push_back(8'h0F);
        issue(3'd6, 2'd0, 16'h0000, 16'h000F, 5);
        waitDone();

        // CLR_FF
        busExp(4'b1100, 1, 8'h00, 0);
        issue(3'd7, 2'd0, 16'h0000, 16'h0000, 5);
        waitDone();

        // WR_WORD_COUNT ch0 with HLDA during the low byte: full restart
        busExp(4'b1100, 1, 8'h00, 0);
        busExp(4'b1100, 1, 8'h00, 0);
        busExp(4'b0001, 1, 8'h78, 1);
        busExp(4'b0001, 1, 8'h56, 1);
        issue(3'd1, 2'd0, 16'h5678, 16'h0000, -1);
        repeat (4) @(negedge CLK);
        chk("hlda_pre_cs", {31'h0, CS_N}, 32'h0);
        HLDA = 1'b1;
        @(negedge CLK);
        chk("hlda_cs", {31'h0, CS_N}, 32'h1);
        chk("hlda_oe", {31'h0, DB_OE}, 32'h0);
        chk("hlda_iow", {31'h0, IOW_N}, 32'h1);
        repeat (2) @(negedge CLK);
        HLDA = 1'b0;
        waitDone();

        // Bus held by DMA while idle blocks new commands
        HLDA = 1'b1;
        #1;
        chk("hlda_idle_ready", {31'h0, cmdReady}, 32'h0);
        @(negedge CLK);
        HLDA = 1'b0;
        #1;
        chk("idle_ready", {31'h0, cmdReady}, 32'h1);
        @(negedge CLK);

        // RD_CUR_ADDR ch0 -> 2211
        busExp(4'b1100, 1, 8'h00, 0);
        busExp(4'b0000, 0, 8'h00, 0);
        busExp(4'b0000, 0, 8'h00, 0);
        rdQ.push_back(8'h11);
        rdQ.push_back(8'h22);
        issue(3'd4, 2'd0, 16'h0000, 16'h2211, 13);
        waitDone();

        // Reset mid-STROBE of WR_COMMAND AA
        busExp(4'b1000, 1, 8'hAA, 1);
        issue(3'd2, 2'd0, 16'h00AA, 16'h0000, 5);
        repeat (2) @(negedge CLK);
        #1;
        chk("strobe_active", {31'h0, IOW_N}, 32'h0);
        RESET_N = 1'b0;
        #1;
        chk("arst_cs", {31'h0, CS_N}, 32'h1);
        chk("arst_iow", {31'h0, IOW_N}, 32'h1);
        chk("arst_oe", {31'h0, DB_OE}, 32'h0);
        chk("arst_a", {28'h0, A}, 32'h0);
        chk("arst_db", {24'h0, DB_OUT}, 32'h0);
        chk("arst_rspd", {16'h0, rspData}, 32'h0);
        rspQ.delete();
        busQ.delete();
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("arst_ready", {31'h0, cmdReady}, 32'h1);

        // WR_WORD_COUNT ch3 BEEF after recovery
        busExp(4'b1100, 1, 8'h00, 0);
        busExp(4'b0111, 1, 8'hEF, 1);
        busExp(4'b0111, 1, 8'hBE, 1);
        issue(3'd1, 2'd3, 16'hBEEF, 16'h0000, 13);
        waitDone();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
